branch_pc_unit: RTL

Registered program-counter and control-flow unit for the single-cycle core; successor to the combinational branch-offset block.
Owns the PC register and decodes JAL/JALR/BRANCH with correct sign extension and signed/unsigned compares.
Produces the next PC, link value and taken flag one cycle after an accepted instruction.
Adds stall handling, misalignment/illegal-branch traps with an acknowledge handshake, and branch statistics counters.

---
 rtl/riscv_pkg.sv | 74 +++++++
 rtl/branch_pc_unit_if.sv | 35 +++
 rtl/branch_cond.sv | 28 ++
 rtl/branch_pc_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types, opcode/funct3 constants and control-flow state enums.
package riscv_pkg;

    typedef struct packed {
        logic       imm20;
        logic [9:0] imm10_1;
        logic       imm11;
        logic [7:0] imm19_12;
        logic [4:0] rd;
        logic [6:0] opcode;
    } J_Type;

    typedef struct packed {
        logic       imm12;
        logic [5:0] imm10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm4_1;
        logic       imm11;
        logic [6:0] opcode;
    } B_Type;

    typedef struct packed {
        logic [11:0] imm11_0;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } I_Type;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_MISALIGNED = 2'd1,
        CAUSE_ILLEGAL    = 2'd2
    } trap_cause_e;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_TRAP
    } pc_state_e;

    // Immediate reassembly; bit 0 of jump/branch offsets is always zero.
    function automatic logic [20:0] j_offset(input logic [31:0] raw);
        J_Type j;
        j = J_Type'(raw);
        return {j.imm20, j.imm19_12, j.imm11, j.imm10_1, 1'b0};
    endfunction

    function automatic logic [12:0] b_offset(input logic [31:0] raw);
        B_Type b;
        b = B_Type'(raw);
        return {b.imm12, b.imm11, b.imm10_5, b.imm4_1, 1'b0};
    endfunction

    function automatic logic [11:0] i_offset(input logic [31:0] raw);
        I_Type i;
        i = I_Type'(raw);
        return i.imm11_0;
    endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Instruction/operand inputs and PC/link/trap/statistics outputs of branch_pc_unit.
interface branch_pc_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      instr;
    logic             instr_valid;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic             stall;
    logic             trap_ack;

    logic [XLEN-1:0]  pc_o;
    logic             pc_valid;
    logic [XLEN-1:0]  link_o;
    logic             link_we;
    logic [4:0]       rd_o;
    logic             taken_o;
    logic             trap_o;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output instr, instr_valid, rs1, rs2, stall, trap_ack,
        input  pc_o, pc_valid, link_o, link_we, rd_o, taken_o,
               trap_o, trap_cause, branch_cnt, taken_cnt
    );

    modport slave (
        input  instr, instr_valid, rs1, rs2, stall, trap_ack,
        output pc_o, pc_valid, link_o, link_we, rd_o, taken_o,
               trap_o, trap_cause, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_cond.sv
// Combinational conditional-branch evaluator: compare result and illegal-funct3 flag.
module branch_cond
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Registered PC and control-flow unit: JAL/JALR/BRANCH decode, link write,
// alignment/illegal-branch traps with acknowledge, and branch statistics.
module branch_pc_unit
    import riscv_pkg::*;
#(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter bit             COMPRESSED   = 1'b0,
    parameter int unsigned    CNT_W        = 32
) (
    input logic              CLK,
    input logic              reset,
    branch_pc_unit_if.slave  bus
);

    pc_state_e       state;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [20:0]     j_raw;
    logic [12:0]     b_raw;
    logic [11:0]     i_raw;
    logic [XLEN-1:0] off_j, off_b, off_i;
    logic [XLEN-1:0] pc_plus4, target;
    logic            is_jal, is_jalr, is_br;
    logic            cond_taken, cond_illegal;
    logic            redirect, misaligned, illegal, fault, accept;

    branch_cond #(.XLEN(XLEN)) u_cond (
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .funct3  (funct3),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    always_comb begin
        opcode   = bus.instr[6:0];
        funct3   = bus.instr[14:12];
        rd       = bus.instr[11:7];
        j_raw    = j_offset(bus.instr);
        b_raw    = b_offset(bus.instr);
        i_raw    = i_offset(bus.instr);
        off_j    = {{(XLEN-21){j_raw[20]}}, j_raw};
        off_b    = {{(XLEN-13){b_raw[12]}}, b_raw};
        off_i    = {{(XLEN-12){i_raw[11]}}, i_raw};

        is_jal   = (opcode == OPC_JAL);
        is_jalr  = (opcode == OPC_JALR);
        is_br    = (opcode == OPC_BRANCH);
        pc_plus4 = bus.pc_o + XLEN'(4);

        if (is_jal)
            target = bus.pc_o + off_j;
        else if (is_jalr)
            target = (bus.rs1 + off_i) & ~XLEN'(1);
        else
            target = bus.pc_o + off_b;

        // Alignment only matters for targets actually taken.
        redirect   = is_jal || is_jalr || (is_br && cond_taken);
        misaligned = redirect && !COMPRESSED && target[1];
        illegal    = is_br && cond_illegal;
        fault      = misaligned || illegal;
        accept     = (state == ST_RUN) && bus.instr_valid && !bus.stall;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state          <= ST_BOOT;
            bus.pc_o       <= RESET_VECTOR;
            bus.pc_valid   <= 1'b0;
            bus.link_o     <= '0;
            bus.link_we    <= 1'b0;
            bus.rd_o       <= '0;
            bus.taken_o    <= 1'b0;
            bus.trap_o     <= 1'b0;
            bus.trap_cause <= CAUSE_NONE;
            bus.branch_cnt <= '0;
            bus.taken_cnt  <= '0;
        end else begin
            bus.taken_o <= 1'b0;
            bus.link_we <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state        <= ST_RUN;
                    bus.pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (accept) begin
                        if (fault) begin
                            state          <= ST_TRAP;
                            bus.pc_valid   <= 1'b0;
                            bus.trap_o     <= 1'b1;
                            bus.trap_cause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
                        end else begin
                            bus.pc_o    <= redirect ? target : pc_plus4;
                            bus.taken_o <= redirect;
                            bus.rd_o    <= rd;
                            if ((is_jal || is_jalr) && (rd != 5'd0)) begin
                                bus.link_we <= 1'b1;
                                bus.link_o  <= pc_plus4;
                            end
                            if (is_br) begin
                                bus.branch_cnt <= bus.branch_cnt + CNT_W'(1);
                                if (cond_taken)
                                    bus.taken_cnt <= bus.taken_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                ST_TRAP: begin
                    if (bus.trap_ack) begin
                        state          <= ST_RUN;
                        bus.pc_o       <= TRAP_VECTOR;
                        bus.pc_valid   <= 1'b1;
                        bus.trap_o     <= 1'b0;
                        bus.trap_cause <= CAUSE_NONE;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule
